// File: rtl/uart_pkg.sv
// Constants shared by the UART transmit and receive paths: FSM state
// encoding, data bits per frame and the idle line level.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the transmitter; extra pointer MSB tells full from empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter for the HC-05 RXD line, 8N1 by default.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 baud_done;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    assign baud_done  = (baud_cnt == BAUD_LAST);
    assign push       = data_valid && !fifo_full;
    assign pop        = !fifo_empty && ((state == IDLE) || (state == STOP && baud_done));
    assign data_ready = !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wr_data(data_in),
        .pop    (pop),
        .rd_data(fifo_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (pop) begin
            shift <= fifo_data;
        end else if (state == DATA && baud_done) begin
            shift <= shift >> 1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (pop) parity <= ^fifo_data;
    end
`endif

    // tx is loaded with the level of the state being entered, so each bit
    // appears on the same edge as the transition that starts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= IDLE_LEVEL;
        end else begin
            if (state == IDLE || baud_done) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + 1'b1;

            case (state)
                IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (pop) begin
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: if (baud_done) begin
                    state   <= DATA;
                    tx      <= shift[0];
                    bit_cnt <= '0;
                end
                DATA: if (baud_done) begin
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= parity;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        tx      <= shift[1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (baud_done) begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
`endif
                STOP: if (baud_done) begin
                    if (pop) begin
                        state <= START;
                        tx    <= 1'b0;
                    end else begin
                        state <= IDLE;
                        tx    <= IDLE_LEVEL;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a per-cycle line model built from queued frames predicts
// tx, busy and data_ready for directed and random traffic.
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       busy;

    uart_tx #(
        .CLK_FREQ  (40),
        .BAUD      (10),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .tx        (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc      = 0;
    int popped   = 0;
    int last_start = 0;
    bit line_q[$];
    int pop_q[$];

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    function automatic void push_bit(input bit b);
        for (int k = 0; k < CPB; k++) line_q.push_back(b);
    endfunction

    function automatic void push_frame(input logic [7:0] d);
        push_bit(1'b0);
        for (int i = 0; i < 8; i++) push_bit(d[i]);
`ifdef UART_TX_PARITY_EN
        push_bit(^d);
`endif
        push_bit(1'b1);
    endfunction

    // Compare the current sample against the model, then drive inputs for the next edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r, output bit took);
        bit from_q;
        bit exp_tx;
        bit exp_dr;
        bit exp_busy;
        int occ;
        while (pop_q.size() > 0 && pop_q[0] <= cyc) begin
            void'(pop_q.pop_front());
            popped++;
        end
        from_q   = (line_q.size() > 0);
        exp_tx   = from_q ? line_q.pop_front() : 1'b1;
        occ      = acc - popped;
        exp_dr   = (occ < DEPTH);
        exp_busy = from_q || (occ > 0);
        check("tx", tx, exp_tx);
        check("busy", busy, exp_busy);
        check("data_ready", data_ready, exp_dr);

        rst        = r;
        data_valid = v;
        data_in    = d;
        took       = v && exp_dr && !r;
        if (r) begin
            line_q.delete();
            pop_q.delete();
            acc    = 0;
            popped = 0;
        end else if (took) begin
            if (line_q.size() == 0) line_q.push_back(1'b1);
            last_start = cyc + 1 + line_q.size();
            pop_q.push_back(last_start);
            push_frame(d);
            acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit t;
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0, t);
    endtask

    task automatic send(input logic [7:0] b);
        bit t;
        int tries;
        t = 1'b0;
        tries = 0;
        while (!t && tries < 100) begin
            step(1'b1, b, 1'b0, t);
            tries++;
        end
        check("accept", t, 1'b1);
    endtask

    logic [7:0] burst [6] = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h81, 8'h3C};

    initial begin
        bit t;
        int s;
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        @(posedge clk);
        #1;
        cyc = 1;

        // Reset held two cycles, then a quiet line with data_in toggling.
        step(1'b0, 8'h00, 1'b1, t);
        step(1'b0, 8'h00, 1'b1, t);
        idle(100);

        // Single byte, then let it drain.
        send(8'hA5);
        step(1'b0, 8'h00, 1'b0, t);
        idle(50);

        // Back-to-back burst with data_valid held high.
        foreach (burst[i]) send(burst[i]);
        step(1'b0, 8'h00, 1'b0, t);
        idle(6 * 11 * CPB + 10);

        // Bytes whose parity bit is 1 and 0 in the parity build.
        send(8'h07);
        idle(50);
        send(8'h03);
        idle(50);

        // Random traffic with random gaps.
        for (int n = 0; n < 24; n++) begin
            send(8'($urandom));
            idle(int'($urandom_range(0, 3)) * (($urandom_range(0, 3) == 0) ? 15 : 1));
        end
        idle(5 * 11 * CPB + 20);

        // Reset during data bit 3 with two bytes still queued.
        send(8'hC3);
        s = last_start;
        send(8'h5A);
        send(8'h96);
        while (cyc < s + CPB * 4 + 1) step(1'b0, 8'h00, 1'b0, t);
        step(1'b0, 8'h00, 1'b1, t);
        idle(100);
        check("model_drained", (line_q.size() == 0) && (acc == popped), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter paired with the existing HC-05 receive path: it accepts bytes from on-chip logic over a valid/ready handshake and buffers them in a small FIFO. It serialises each byte onto the HC-05 RXD line as 8N1 (optionally 8E1), LSB first. It is the outbound half of the Bluetooth link and sits between the command/telemetry logic and the module's RXD pin.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be ≥ 2).
- FIFO_DEPTH, 4: byte buffer entries; power of two, ≥ 2.
- clk  input  1  system clock; everything on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- data_in  input  8  byte to send; sampled when data_valid && data_ready.
- data_valid  input  1  producer holds data_in valid.
- data_ready  output  1  FIFO can accept; equals !fifo_full, registered.
- tx  output  1  serial line to HC-05 RXD; idle high, registered.
- busy  output  1  high while the FSM is not IDLE or the FIFO is non-empty.

## Operation
- Handshake: push on a cycle where data_valid && data_ready. data_valid without data_ready has no effect; the producer must hold data_in and data_valid.
- FSM states:
  - IDLE: tx=1. If the FIFO is non-empty, pop into a 8-bit shift register, clear the baud counter, go to START.
  - START: tx=0.
  - DATA: tx = shift[0]; shift right each bit period; 8 bits.
  - PARITY: only with macro.
  - STOP: tx=1.
- Transitions happen when the baud counter reaches CLKS_PER_BIT-1. The counter then wraps to 0.
- From STOP, if the FIFO is non-empty, pop and go directly to START. There is no idle bit between frames. Otherwise go to IDLE.
- Bit counter is 3 bits, 0..7. DATA exits after count 7 at baud wrap.
- Baud counter width is $clog2(CLKS_PER_BIT). It is held at 0 in IDLE, so bit phase is aligned to frame start.
- Push into a full FIFO is impossible because data_ready is low.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- Pop and push on an empty FIFO in the same cycle: the FSM sees the new byte only on the next cycle. There is no bypass.

## Timing
- Reset values: tx=1, data_ready=1, busy=0. FIFO is empty, FSM is IDLE, counters are 0.
- Reset asserted mid-frame: on the next edge tx=1, the frame is truncated, and FIFO contents are discarded.
- Latency when idle with an empty FIFO: byte accepted at edge N, FIFO non-empty after N, pop at edge N+1, tx falls at edge N+1. busy rises at edge N.
- Each bit is held exactly CLKS_PER_BIT cycles.
- Frame length is 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- data_ready falls the edge after the push that fills the FIFO. It rises the edge after the pop that frees a slot.
- busy falls on the edge the FSM returns to IDLE from STOP with the FIFO empty.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state follows DATA and transmits even parity (XOR of the 8 data bits) for one bit period; the frame is 8E1.
  - Undefined: DATA goes straight to STOP; the frame is 8N1 and no parity logic is synthesised.

## Structure
- Shared package uart_pkg holds the FSM state encoding (IDLE, START, DATA, PARITY, STOP), DATA_BITS=8, and the idle line level constant. The receive path reuses the same constants.
- One sub-module, uart_tx_fifo: synchronous FIFO with FIFO_DEPTH entries, 8 bits wide. It has push/pop/full/empty signals and pointer wrap-around by $clog2(FIFO_DEPTH)+1-bit pointers. The baud counter and FSM are inline in uart_tx.

## Test plan
All scenarios use CLK_FREQ=40, BAUD=10, so CLKS_PER_BIT=4.
- Reset: rst high for 2 cycles, then low, data_valid=0 → tx=1, data_ready=1, busy=0 for 50 cycles.
- Single byte 0xA5 accepted at edge N → tx falls at N+1. Line carries 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. busy falls 40 cycles after N+1.
- Burst 0x00, 0xFF, 0x55, 0x0F, 0x81, 0x3C with data_valid held high:
  - data_ready deasserts once 4 bytes are queued.
  - All 6 bytes go out in order, back-to-back, with stop→start adjacent and no extra high cycles.
- Parity build (UART_TX_PARITY_EN), byte 0x07 → bit after the data bits is 1. Frame length is 44 cycles. Byte 0x03 → parity bit is 0.
- Reset mid-frame during data bit 3 with 2 bytes queued → tx=1 on the next edge, busy=0, data_ready=1. No further start bit appears in 100 cycles.
- data_valid low while data_in toggles randomly for 100 cycles → tx constant 1, busy=0.
